alsu_cmd_sequencer: RTL and testbench
=====================================

Name: alsu_cmd_sequencer

Overview:
Upstream feeder for the ALSU. It accepts packed ALSU commands over a valid/ready interface and buffers them in a small FIFO. Each command is driven onto the ALSU input pins for 1..8 consecutive cycles, so shift and rotate chains are possible. The block then collects the ALSU result, aligned to the ALSU's fixed two-register latency and tagged with the command ID and a locally computed invalid flag.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, 2..8.
PIPE_LAT, 2, ALSU latency in clocks from a pin change to the matching out value (input reg + output reg).
IDLE_CTRL, 16'h0000, pin pattern driven whenever no command is being issued.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept; transfer when cmd_valid && cmd_ready at posedge
cmd_data  in  16  packed ALSU command, layout below
cmd_rep  in  3  repeat count; command is issued cmd_rep+1 cycles
cmd_id  in  4  tag returned with every result of this command
alsu_ctrl  out  16  packed ALSU pin bundle, same layout as cmd_data, registered
alsu_out  in  6  ALSU out (signed)
res_valid  out  1  one-cycle pulse per issued cycle
res_data  out  6  captured alsu_out
res_id  out  4  tag of the issuing command
res_invalid  out  1  issued pattern was invalid (ALSU forces 0 / blinks leds)
busy  out  1  FIFO non-empty, issuing, or results in flight
fifo_count  out  4  current FIFO occupancy

Behaviour:
- Bit layout of cmd_data and alsu_ctrl:
  - [15:13] A, [12:10] B, [9:7] opcode, [6] cin, [5] serial_in
  - [4] red_op_A, [3] red_op_B, [2] bypass_A, [1] bypass_B, [0] direction
- Reset (rst low, asynchronous): FIFO emptied, fifo_count=0, alsu_ctrl=IDLE_CTRL, res_valid=0, res_data=0, res_id=0, res_invalid=0, busy=0, state=IDLE. The in-flight tracker is cleared, so results of commands issued before reset are never reported.
- cmd_ready = (fifo_count < FIFO_DEPTH). It is combinational from the count only, never from cmd_valid.
- FIFO entry width is 23 bits: data, rep, id.
- Simultaneous push and pop when full:
  - The pop frees a slot, but cmd_ready was low that cycle, so there is no push.
  - When not full, simultaneous push and pop leaves the count unchanged.
- FSM states: IDLE, ISSUE.
  - IDLE: alsu_ctrl=IDLE_CTRL. If the FIFO is non-empty, pop the head at the posedge: load alsu_ctrl=head.data, rep_cnt=head.rep, cur_id=head.id, go to ISSUE.
  - ISSUE: alsu_ctrl is held. Each cycle, if rep_cnt!=0 then rep_cnt-1.
  - When rep_cnt==0 and the FIFO is non-empty: pop and load the next command back-to-back, with no IDLE bubble.
  - When rep_cnt==0 and the FIFO is empty: go to IDLE.
- One issue slot = one clock in which alsu_ctrl holds a command (ISSUE state). IDLE cycles are not issue slots.
- Each issue slot pushes {1, cur_id, inv} into a tracker shift register of depth PIPE_LAT+1.
  - The tail entry drives res_valid/res_id/res_invalid. res_data samples alsu_out at the same edge.
  - Net effect: a pin value registered at edge t produces res_valid high in the cycle after edge t+PIPE_LAT+1.
- inv = ((red_op_A|red_op_B) & (opcode[1]|opcode[2])) | (opcode[1]&opcode[2]), computed from the issued pins.
  - Bypass overrides this: when bypass_A|bypass_B is set, inv=0.
- A command with cmd_rep=N yields N+1 results, all with the same id, in order.
  - Shift/rotate commands accumulate across repeats, because ALSU out is fed back.
- IDLE_CTRL cycles reset the ALSU's out to 0 (opcode 0, operands 0). Shift chains must therefore be issued as one command with repeats.
- busy = (fifo_count!=0) | (state==ISSUE) | any tracker valid.
- Result ordering is strictly issue order. There is no backpressure on results: the consumer must accept every pulse.

Test Plan:
- Reset: drive rst low mid-ISSUE with 2 results in flight -> alsu_ctrl=16'h0000 and res_valid=0 at once; no stale results after release; fifo_count=0.
- Single ADD: A=3, B=2, cin=1, opcode=2, rep=0, id=5 -> exactly one res_valid pulse, 4 cycles after the command is accepted; res_data=6, res_id=5, res_invalid=0.
- Back-to-back: MUL A=-3, B=3, id=1, then XOR A=3'b101, B=3'b011, id=2, both pushed in consecutive cycles -> consecutive res_valid pulses; res_data=6'h37 (id 1), then 6'h3E (id 2).
- Repeat shift: opcode=4, direction=1, serial_in=1, rep=3, preceded by IDLE -> 4 pulses with res_data=1, 3, 7, 15, all the same id.
- Full FIFO: hold cmd_valid with a stalled sequence (rep=7 command first) -> cmd_ready drops at fifo_count=4; no entry lost or duplicated; ids are reported in push order.
- Invalid tagging: opcode=6 -> res_invalid=1, res_data=0. Opcode=2 with red_op_A=1 -> res_invalid=1. Opcode=6 with bypass_A=1, A=3 -> res_invalid=0, res_data=3.

Source files
------------

// File: rtl/alsu_cmd_sequencer.sv
// alsu_cmd_sequencer: buffers ALSU commands, issues each for 1..8 cycles and collects latency-aligned tagged results
module alsu_cmd_sequencer #(
  parameter int          FIFO_DEPTH = 4,
  parameter int          PIPE_LAT   = 2,
  parameter logic [15:0] IDLE_CTRL  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_data,
  input  logic [2:0]  cmd_rep,
  input  logic [3:0]  cmd_id,
  output logic [15:0] alsu_ctrl,
  input  logic [5:0]  alsu_out,
  output logic        res_valid,
  output logic [5:0]  res_data,
  output logic [3:0]  res_id,
  output logic        res_invalid,
  output logic        busy,
  output logic [3:0]  fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t                r_state, w_state_nxt;
  logic [22:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wp, r_rp;
  logic [3:0]            r_cnt;
  logic [15:0]           r_ctrl;
  logic [2:0]            r_rep;
  logic [3:0]            r_id;
  logic [PIPE_LAT:0]     r_tv, r_tinv;
  logic [PIPE_LAT:0][3:0] r_tid;
  logic [5:0]            r_res_data;
  logic                  w_push, w_pop, w_inv, w_issue;
  logic [22:0]           w_head;
  assign w_head      = r_mem[r_rp];
  assign cmd_ready   = r_cnt < 4'(FIFO_DEPTH);
  assign w_push      = cmd_valid & cmd_ready;
  assign w_issue     = r_state == ISSUE;
  assign w_inv       = ~(r_ctrl[2] | r_ctrl[1]) &
                       (((r_ctrl[4] | r_ctrl[3]) & (r_ctrl[8] | r_ctrl[9])) | (r_ctrl[8] & r_ctrl[9]));
  assign alsu_ctrl   = r_ctrl;
  assign fifo_count  = r_cnt;
  assign res_valid   = r_tv[PIPE_LAT];
  assign res_id      = r_tid[PIPE_LAT];
  assign res_invalid = r_tinv[PIPE_LAT];
  assign res_data    = r_res_data;
  assign busy        = (r_cnt != '0) | w_issue | (|r_tv);
  // FIFO storage: entries only become visible through the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {cmd_data, cmd_rep, cmd_id};
  end
  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + 4'(w_push) - 4'(w_pop);
    end
  end
  // Pop whenever the current command has finished its last repeat (or nothing is issuing)
  always_comb begin
    w_pop       = (r_cnt != '0) && (r_state == IDLE || r_rep == '0);
    w_state_nxt = (w_pop || (w_issue && r_rep != '0)) ? ISSUE : IDLE;
  end
  // State register plus the issued pin bundle, repeat counter and tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ctrl  <= IDLE_CTRL;
      r_rep   <= '0;
      r_id    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_ctrl <= w_head[22:7];
        r_rep  <= w_head[6:4];
        r_id   <= w_head[3:0];
      end else if (w_issue && r_rep != '0) begin
        r_rep <= r_rep - 3'd1;
      end else begin
        r_ctrl <= IDLE_CTRL;
      end
    end
  end
  // In-flight tracker: each issue slot travels PIPE_LAT+1 stages to meet its ALSU result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tv       <= '0;
      r_tinv     <= '0;
      r_tid      <= '0;
      r_res_data <= '0;
    end else begin
      r_tv   <= {r_tv[PIPE_LAT-1:0], w_issue};
      r_tinv <= {r_tinv[PIPE_LAT-1:0], w_issue & w_inv};
      r_tid  <= {r_tid[PIPE_LAT-1:0], r_id};
      if (r_tv[PIPE_LAT-1]) r_res_data <= alsu_out;
    end
  end
endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// tb_alsu_cmd_sequencer: directed vectors with a queue scoreboard and an ALSU environment model
module tb_alsu_cmd_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [2:0]  cmd_rep;
  logic [3:0]  cmd_id;
  logic [15:0] alsu_ctrl;
  logic [5:0]  alsu_out;
  logic        res_valid;
  logic [5:0]  res_data;
  logic [3:0]  res_id;
  logic        res_invalid;
  logic        busy;
  logic [3:0]  fifo_count;
  logic [15:0] m_in;
  logic [10:0] sb [$];
  logic        ignore = 1'b0;
  int          checks = 0;
  int          fails = 0;
  int          n;

  alsu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep), .cmd_id(cmd_id), .alsu_ctrl(alsu_ctrl),
    .alsu_out(alsu_out), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_invalid(res_invalid), .busy(busy), .fifo_count(fifo_count)
  );

  // clock generation
  always #5 clk = ~clk;

  function automatic logic [5:0] sx(input logic [2:0] v);
    return {{3{v[2]}}, v};
  endfunction

  // behavioural ALSU: one output step from registered pins and the fed-back out
  function automatic logic [5:0] alsu_f(input logic [15:0] c, input logic [5:0] o);
    logic signed [2:0] a, b;
    logic signed [5:0] r;
    logic [2:0] op;
    a  = c[15:13];
    b  = c[12:10];
    op = c[9:7];
    if (c[2]) return sx(a);
    if (c[1]) return sx(b);
    if (((c[4] | c[3]) & (op[1] | op[2])) | (op[1] & op[2])) return 6'd0;
    case (op)
      3'd0: r = c[4] ? {5'd0, &a} : c[3] ? {5'd0, &b} : sx(a & b);
      3'd1: r = c[4] ? {5'd0, ^a} : c[3] ? {5'd0, ^b} : sx(a ^ b);
      3'd2: r = a + b + $signed({1'b0, c[6]});
      3'd3: r = a * b;
      3'd4: r = c[0] ? {o[4:0], c[5]} : {c[5], o[5:1]};
      default: r = c[0] ? {o[4:0], o[5]} : {o[0], o[5:1]};
    endcase
    return r;
  endfunction

  // ALSU environment: input register then output register
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_in     <= '0;
      alsu_out <= '0;
    end else begin
      m_in     <= alsu_ctrl;
      alsu_out <= alsu_f(m_in, alsu_out);
    end
  end

  // monitor: every result pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst && res_valid && !ignore) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL res_unexpected got id=%0d data=%0h inv=%0b required none", res_id, res_data, res_invalid);
      end else begin
        logic [10:0] e;
        e = sb.pop_front();
        if ({res_id, res_data, res_invalid} !== e) begin
          fails++;
          $display("FAIL res got id=%0d data=%0h inv=%0b required id=%0d data=%0h inv=%0b",
                   res_id, res_data, res_invalid, e[10:7], e[6:1], e[0]);
        end
      end
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] a, b, op, input logic cin, sin, ra, rb, ba, bb, dir);
    return {a, b, op, cin, sin, ra, rb, ba, bb, dir};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", nm, got, req);
    end
  endtask

  task automatic exp(input logic [3:0] id, input logic [5:0] d, input logic inv);
    sb.push_back({id, d, inv});
  endtask

  task automatic push(input logic [15:0] d, input logic [2:0] rep, input logic [3:0] id);
    int k;
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_rep   = rep;
    cmd_id    = id;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cmd_ready && k < 100);
    if (!cmd_ready) begin
      checks++;
      fails++;
      $display("FAIL push_timeout id=%0d got cmd_ready=0 required 1", id);
    end else begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((busy || sb.size() != 0) && k < 300) begin
      @(posedge clk);
      k++;
    end
    chk("drain", {31'd0, k < 300}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // watchdog
  initial begin
    #300000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1);
  end

  // directed stimulus
  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_rep = '0; cmd_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'(alsu_ctrl), 32'h0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // single ADD: 3+2+1
    exp(4'd5, 6'd6, 1'b0);
    push(mk(3'd3, 3'd2, 3'd2, 1, 0, 0, 0, 0, 0, 0), 3'd0, 4'd5);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!res_valid && n < 20);
    chk("add_latency", n, 32'd4);
    drain();
    // back-to-back MUL then XOR
    exp(4'd1, 6'h37, 1'b0);
    exp(4'd2, 6'h3E, 1'b0);
    push(mk(3'b101, 3'd3, 3'd3, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd1);
    push(mk(3'b101, 3'b011, 3'd1, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 20);
    @(negedge clk);
    chk("b2b_consecutive", 32'(res_valid), 32'd1);
    drain();
    // shift left with serial_in=1, four issue slots
    exp(4'd3, 6'd1, 1'b0);
    exp(4'd3, 6'd3, 1'b0);
    exp(4'd3, 6'd7, 1'b0);
    exp(4'd3, 6'd15, 1'b0);
    push(mk(3'd0, 3'd0, 3'd4, 0, 1, 0, 0, 0, 0, 1), 3'd3, 4'd3);
    drain();
    // full FIFO behind a long command
    for (int i = 0; i < 8; i++) exp(4'd1, 6'd2, 1'b0);
    exp(4'd2, 6'd3, 1'b0);
    exp(4'd3, 6'd4, 1'b0);
    exp(4'd4, 6'd5, 1'b0);
    exp(4'd5, 6'd6, 1'b0);
    exp(4'd6, 6'd7, 1'b0);
    push(mk(3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd7, 4'd1);
    push(mk(3'd2, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd2);
    push(mk(3'd3, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd3);
    push(mk(3'd3, 3'd2, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd4);
    push(mk(3'd3, 3'd3, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd5);
    cmd_valid = 1'b1;
    cmd_data  = mk(3'd3, 3'd3, 3'd2, 1, 0, 0, 0, 0, 0, 0);
    cmd_rep   = 3'd0;
    cmd_id    = 4'd6;
    @(negedge clk);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    push(mk(3'd3, 3'd3, 3'd2, 1, 0, 0, 0, 0, 0, 0), 3'd0, 4'd6);
    drain();
    // invalid tagging and bypass override
    exp(4'd7, 6'd0, 1'b1);
    exp(4'd8, 6'd0, 1'b1);
    exp(4'd9, 6'd3, 1'b0);
    push(mk(3'd0, 3'd0, 3'd6, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd7);
    push(mk(3'd3, 3'd2, 3'd2, 0, 0, 1, 0, 0, 0, 0), 3'd0, 4'd8);
    push(mk(3'd3, 3'd0, 3'd6, 0, 0, 0, 0, 1, 0, 0), 3'd0, 4'd9);
    drain();
    // reset mid-issue with results in flight and one command queued
    ignore = 1'b1;
    push(mk(3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd7, 4'd10);
    push(mk(3'd2, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0), 3'd0, 4'd11);
    repeat (2) @(posedge clk);
    #2;
    chk("pre_rst_count", 32'(fifo_count), 32'd1);
    chk("pre_rst_ctrl", 32'(alsu_ctrl), 32'(mk(3'd1, 3'd1, 3'd2, 0, 0, 0, 0, 0, 0, 0)));
    rst = 1'b0;
    #1;
    chk("arst_ctrl", 32'(alsu_ctrl), 32'h0);
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    ignore = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    drain();
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
